// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial add/sub engine: one full-adder slice iterated LSB first over WIDTH cycles.
// Latency WIDTH+1 cycles start->done; start is ignored unless ready (no queueing).
module bit_serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carryOut,
   output logic             overflow
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q,  state_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic             carry_q,  carry_d;
   logic [WIDTH-1:0] opa_q,    opa_d;
   logic [WIDTH-1:0] opb_q,    opb_d;
   logic [WIDTH-2:0] sum_q,    sum_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q,   cout_d;
   logic             ovf_q,    ovf_d;

   logic             sum_bit;
   logic             cout_bit;
   logic [WIDTH-1:0] sum_full;

   assign sum_bit  = opa_q[0] ^ opb_q[0] ^ carry_q;
   assign cout_bit = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
   // Low WIDTH-1 sum bits are already aligned in sum_q by the final RUN edge.
   assign sum_full = {sum_bit, sum_q};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      sum_d    = sum_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               opa_d   = a;
               opb_d   = b ^ {WIDTH{sub}};
               carry_d = sub;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d   = sum_full[WIDTH-1:1];
            opa_d   = {1'b0, opa_q[WIDTH-1:1]};
            opb_d   = {1'b0, opb_q[WIDTH-1:1]};
            carry_d = cout_bit;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               // carry_q here is the carry into the MSB, captured on the previous edge.
               result_d = sum_full;
               cout_d   = cout_bit;
               ovf_d    = carry_q ^ cout_bit;
               state_d  = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         opa_q    <= '0;
         opb_q    <= '0;
         sum_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         sum_q    <= sum_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign ready    = (state_q == S_IDLE);
   assign busy     = (state_q == S_RUN) || (state_q == S_DONE);
   assign done     = (state_q == S_DONE);
   assign result   = result_q;
   assign carryOut = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Directed bench for bit_serial_adder_ctrl (WIDTH=8) with hand-computed expectations.
module tb_bit_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       sub;
   logic [7:0] a;
   logic [7:0] b;
   logic       ready;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       carryOut;
   logic       overflow;

   int checks   = 0;
   int failures = 0;

   bit_serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
      .ready(ready), .busy(busy), .done(done), .result(result),
      .carryOut(carryOut), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation; lat = RUN edges until done (or -1), mid_res = result after RUN edge 3.
   task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                        output int lat, output logic [7:0] mid_res);
      @(negedge clk);
      a = av; b = bv; sub = sv; start = 1'b1;
      tick();
      start = 1'b0;
      lat = -1;
      mid_res = 8'hxx;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (n == 3) mid_res = result;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00;
      repeat (3) tick();
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if ({result, carryOut, overflow} !== 10'h000) begin failures++; $display("FAIL reset_outputs got=%h/%b/%b exp=00/0/0", result, carryOut, overflow); end
      @(negedge clk);
      reset = 1'b0;
      tick();
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", ready); end
   endtask

   task automatic test_add_basic();
      int lat;
      logic [7:0] mid;
      do_op(8'h5A, 8'h3C, 1'b0, lat, mid);
      checks++; if (lat !== 8) begin failures++; $display("FAIL add1_latency got=%0d exp=8", lat); end
      checks++; if (result !== 8'h96) begin failures++; $display("FAIL add1_result got=%h exp=96", result); end
      checks++; if (carryOut !== 1'b0) begin failures++; $display("FAIL add1_carry got=%b exp=0", carryOut); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL add1_overflow got=%b exp=1", overflow); end
      checks++; if (busy !== 1'b1 || ready !== 1'b0) begin failures++; $display("FAIL add1_done_busy got=%b/%b exp=1/0", busy, ready); end
      tick();
      checks++; if (ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL add1_return_idle got=%b/%b exp=1/0", ready, done); end
   endtask

   task automatic test_add_wrap();
      int lat;
      logic [7:0] mid;
      do_op(8'hFF, 8'h01, 1'b0, lat, mid);
      checks++; if (mid !== 8'h96) begin failures++; $display("FAIL wrap_hold_during_run got=%h exp=96", mid); end
      checks++; if (lat !== 8) begin failures++; $display("FAIL wrap_latency got=%0d exp=8", lat); end
      checks++; if ({result, carryOut, overflow} !== {8'h00, 1'b1, 1'b0}) begin failures++; $display("FAIL wrap_outputs got=%h/%b/%b exp=00/1/0", result, carryOut, overflow); end
      tick();
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL wrap_ready got=%b exp=1", ready); end
   endtask

   task automatic test_sub();
      int lat;
      logic [7:0] mid;
      do_op(8'h10, 8'h20, 1'b1, lat, mid);
      checks++; if (lat !== 8) begin failures++; $display("FAIL sub1_latency got=%0d exp=8", lat); end
      checks++; if ({result, carryOut, overflow} !== {8'hF0, 1'b0, 1'b0}) begin failures++; $display("FAIL sub1_outputs got=%h/%b/%b exp=f0/0/0", result, carryOut, overflow); end
      tick();
      do_op(8'h80, 8'h01, 1'b1, lat, mid);
      checks++; if (lat !== 8) begin failures++; $display("FAIL sub2_latency got=%0d exp=8", lat); end
      checks++; if ({result, carryOut, overflow} !== {8'h7F, 1'b1, 1'b1}) begin failures++; $display("FAIL sub2_outputs got=%h/%b/%b exp=7f/1/1", result, carryOut, overflow); end
      tick();
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL sub2_ready got=%b exp=1", ready); end
   endtask

   task automatic test_ignore_start();
      int lat = -1;
      int extra_done = 0;
      @(negedge clk);
      a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (n == 3) begin a = 8'h55; b = 8'h55; sub = 1'b1; start = 1'b1; end
         if (n == 4) start = 1'b0;
         if (done) begin
            lat = n;
            break;
         end
      end
      checks++; if (lat !== 8) begin failures++; $display("FAIL ignore_latency got=%0d exp=8", lat); end
      checks++; if ({result, carryOut, overflow} !== {8'h33, 1'b0, 1'b0}) begin failures++; $display("FAIL ignore_outputs got=%h/%b/%b exp=33/0/0", result, carryOut, overflow); end
      for (int n = 0; n < 15; n++) begin
         tick();
         if (done) extra_done++;
      end
      checks++; if (extra_done !== 0) begin failures++; $display("FAIL ignore_second_done got=%0d exp=0", extra_done); end
      checks++; if (ready !== 1'b1 || result !== 8'h33) begin failures++; $display("FAIL ignore_idle got=%b/%h exp=1/33", ready, result); end
   endtask

   task automatic test_back_to_back();
      int done_cnt = 0;
      int ready_cnt = 0;
      int first_done = -1;
      int last_done = -1;
      @(negedge clk);
      a = 8'hFF; b = 8'h02; sub = 1'b0; start = 1'b1;
      for (int k = 0; k <= 30; k++) begin
         tick();
         if (done) begin
            done_cnt++;
            if (first_done < 0) first_done = k;
            last_done = k;
         end
         if (ready) ready_cnt++;
      end
      start = 1'b0;
      checks++; if (done_cnt !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", done_cnt); end
      checks++; if (first_done !== 8) begin failures++; $display("FAIL b2b_first_done got=%0d exp=8", first_done); end
      checks++; if (last_done - first_done !== 20) begin failures++; $display("FAIL b2b_period_span got=%0d exp=20", last_done - first_done); end
      checks++; if (ready_cnt !== 3) begin failures++; $display("FAIL b2b_ready_cycles got=%0d exp=3", ready_cnt); end
      checks++; if ({result, carryOut, overflow} !== {8'h01, 1'b1, 1'b0}) begin failures++; $display("FAIL b2b_outputs got=%h/%b/%b exp=01/1/0", result, carryOut, overflow); end
      for (int n = 0; n < 20 && !ready; n++) tick();
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_drain_ready got=%b exp=1", ready); end
   endtask

   task automatic test_reset_midrun();
      int lat;
      int stray_done = 0;
      logic [7:0] mid;
      @(negedge clk);
      a = 8'hAA; b = 8'h55; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      #2;
      reset = 1'b1;
      #1;
      checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_flags got=%b/%b/%b exp=1/0/0", ready, busy, done); end
      checks++; if ({result, carryOut, overflow} !== 10'h000) begin failures++; $display("FAIL midrst_outputs got=%h/%b/%b exp=00/0/0", result, carryOut, overflow); end
      tick();
      @(negedge clk);
      reset = 1'b0;
      for (int n = 0; n < 10; n++) begin
         tick();
         if (done) stray_done++;
      end
      checks++; if (stray_done !== 0 || ready !== 1'b1) begin failures++; $display("FAIL midrst_no_done got=%0d/%b exp=0/1", stray_done, ready); end
      do_op(8'h01, 8'h02, 1'b0, lat, mid);
      checks++; if (lat !== 8) begin failures++; $display("FAIL midrst_fresh_latency got=%0d exp=8", lat); end
      checks++; if ({result, carryOut, overflow} !== {8'h03, 1'b0, 1'b0}) begin failures++; $display("FAIL midrst_fresh_outputs got=%h/%b/%b exp=03/0/0", result, carryOut, overflow); end
      tick();
   endtask

   initial begin
      test_reset();
      test_add_basic();
      test_add_wrap();
      test_sub();
      test_ignore_start();
      test_back_to_back();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
